ece453_debounce_bank: RTL
=========================

# ece453_debounce_bank

Parametrised, multi-channel successor to the single-input push-button debouncer. It conditions `CHANNELS` raw asynchronous inputs (buttons, slide switches) into clean levels and emits one-cycle rise/fall pulses. It latches masked edge events into sticky pending bits with write-1-to-clear and drives a single interrupt line. It sits between the board `gpio_inputs` pins and the Avalon register block and control FSMs.

## Interface
- `CHANNELS`, 8: number of independent input channels (≥1).
- `TICK_DIV`, 500000: clock cycles between sample ticks (≥1; 1 = sample every cycle).
- `SAMPLES`, 4: consecutive disagreeing samples required to flip a debounced level (≥1).
- `RESET_LEVEL`, 0: debounced level (applied to all channels) after reset.
- Clocking: one clock; reset is asynchronous and active-high.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `raw_in` in CHANNELS: unsynchronised pin inputs.
- `rise_en` in CHANNELS: per-channel enable for latching rising-edge events.
- `fall_en` in CHANNELS: per-channel enable for latching falling-edge events.
- `event_clear` in CHANNELS: write-1-to-clear strobe for `event_pending`; sampled every cycle.
- `level_out` out CHANNELS: registered debounced level.
- `rise_pulse` out CHANNELS: one-cycle pulse when `level_out` goes 0→1.
- `fall_pulse` out CHANNELS: one-cycle pulse when `level_out` goes 1→0.
- `event_pending` out CHANNELS: sticky latched edge events.
- `irq_out` out 1: `|event_pending`, combinational from registered bits.

## Operation
- Synchroniser: two flops per channel, both reset to `RESET_LEVEL`; no spurious edge out of reset.
- Prescaler: a single shared down-counter, width `$clog2(TICK_DIV)` (min 1).
  - Resets to `TICK_DIV-1`.
  - `tick` = (count == 0); on tick it reloads `TICK_DIV-1`, otherwise decrements.
- Per-channel counter `cnt`, width `$clog2(SAMPLES+1)`, resets to 0. On a tick cycle:
  - If synced input equals `level_out`, `cnt` returns to 0.
  - Otherwise, if `cnt == SAMPLES-1`: `level_out` toggles and `cnt` returns to 0.
  - Otherwise `cnt` increments.
- Non-tick cycles: `cnt` and `level_out` hold.
- A glitch that disagrees for fewer than `SAMPLES` consecutive ticks produces no level change.
- `rise_pulse`/`fall_pulse` are registered and high in exactly the cycle `level_out` first shows the new value. Both are low otherwise; they are never high together on one channel.
- Pending bit, per channel:
  - set = (`rise_pulse` & `rise_en`) | (`fall_pulse` & `fall_en`).
  - Next value = set | (pending & ~`event_clear`). Set wins over a simultaneous clear.
  - Clearing a bit that is not pending has no effect.
- Channels are fully independent; simultaneous flips on several channels are all reported in the same cycle.

## Timing
- Reset values:
  - `level_out` = {CHANNELS{RESET_LEVEL}}.
  - `rise_pulse`, `fall_pulse`, `event_pending` = 0; `irq_out` = 0.
  - Prescaler = `TICK_DIV-1`; all `cnt` = 0.
- Reset asserted mid-count: everything returns to reset values immediately, with no pulse emitted on deassertion.
- Latency from a stable `raw_in` change to the `level_out` change is 3 + (SAMPLES-1)·TICK_DIV + w cycles, where w ∈ [0, TICK_DIV-1] depends on prescaler phase.
- `event_pending` sets one cycle after the pulse; `irq_out` rises in that same cycle.
- `event_clear` takes effect on the next edge; `irq_out` falls the cycle after the clear when no other bit is pending.
- Enable masks are sampled in the cycle the pulse is high. Changing an enable afterwards does not retroactively set or clear pending bits.

## Test plan
Bench parameters: CHANNELS=4, TICK_DIV=4, SAMPLES=3, RESET_LEVEL=0.
- Reset: after reset release with `raw_in`=0, hold 50 cycles -> `level_out`=0, no pulses, `irq_out`=0.
- Clean press: `raw_in[0]` 0→1 and held.
  - `level_out[0]` rises between 11 and 14 cycles later.
  - `rise_pulse[0]` is high for exactly 1 cycle.
  - With `rise_en[0]`=1, `event_pending`=4'b0001 and `irq_out`=1 one cycle after the pulse.
- Glitch reject: `raw_in[1]` high for 8 cycles, then low -> `level_out[1]` stays 0, no pulses, `event_pending[1]`=0.
- Release and mask: with `fall_en`=0, `raw_in[0]` 1→0 -> `fall_pulse[0]` is high 1 cycle, but `event_pending[0]` is not set by the fall.
- Clear race: `event_clear[2]` asserted in the same cycle that `rise_pulse[2]` & `rise_en[2]` sets the bit -> `event_pending[2]` remains 1. A clear pulse one cycle later -> 0, and `irq_out`=0 if no other bits are pending.
- Mid-count reset and parallel channels:
  - Drive `raw_in`=4'b1111 and assert `reset` after 2 ticks -> all outputs return to 0 and no pulse appears after release.
  - Re-drive `raw_in`=4'b1111 -> all four `rise_pulse` bits fire in the same cycle.

Source files
------------

// File: rtl/ece453_debounce_bank.sv
// Multi-channel input debouncer: two-flop synchroniser, shared sample-tick prescaler,
// per-channel consecutive-sample counter, registered edge pulses and sticky W1C event bits.
module ece453_debounce_bank #(
  parameter int   CHANNELS    = 8,
  parameter int   TICK_DIV    = 500000,
  parameter int   SAMPLES     = 4,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  input  logic [CHANNELS-1:0] rise_en,
  input  logic [CHANNELS-1:0] fall_en,
  input  logic [CHANNELS-1:0] event_clear,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] event_pending,
  output logic                irq_out
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(SAMPLES + 1);
  localparam logic [PW-1:0] PRESCALE_RELOAD = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST        = CW'(SAMPLES - 1);

  logic [CHANNELS-1:0] sync1;
  logic [CHANNELS-1:0] sync2;
  logic [PW-1:0]       prescale;
  logic                tick;
  logic [CW-1:0]       cnt [CHANNELS];
  logic [CHANNELS-1:0] flip;

  // Synchroniser flops reset to the debounced reset level so release never looks like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= {CHANNELS{RESET_LEVEL}};
      sync2 <= {CHANNELS{RESET_LEVEL}};
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  assign tick = (prescale == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale <= PRESCALE_RELOAD;
    end else if (tick) begin
      prescale <= PRESCALE_RELOAD;
    end else begin
      prescale <= prescale - PW'(1);
    end
  end

  // A channel flips on the tick that completes SAMPLES consecutive disagreeing samples.
  always_comb begin
    flip = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      flip[i] = tick && (sync2[i] != level_out[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_out  <= {CHANNELS{RESET_LEVEL}};
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      level_out  <= level_out ^ flip;
      rise_pulse <= flip & ~level_out;
      fall_pulse <= flip & level_out;
      for (int i = 0; i < CHANNELS; i++) begin
        if (tick) begin
          if ((sync2[i] == level_out[i]) || flip[i]) begin
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
    end
  end

  // New events win over a clear issued in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      event_pending <= '0;
    end else begin
      event_pending <= (rise_pulse & rise_en) | (fall_pulse & fall_en)
                     | (event_pending & ~event_clear);
    end
  end

  assign irq_out = |event_pending;

endmodule
